// File: rtl/layer1_seq_if.sv
// Stream, memory-command and read-service signals of the first-layer sequencer.
interface layer1_seq_if;
  logic              in_valid;
  logic              in_ready;
  logic signed [7:0] in_data;

  logic              store;
  logic [9:0]        w_addr;
  logic [3:0]        out_c;
  logic signed [7:0] bias;
  logic signed [7:0] value;
  logic              cout_done;
  logic              pool;
  logic              pool_done;
  logic              load;
  logic [9:0]        addr1;
  logic [9:0]        addr2;

  logic              rd_req;
  logic [7:0]        rd_idx;
  logic              rd_last;
  logic              rd_valid;

  modport slave (
    input  in_valid, in_data, pool_done, rd_req, rd_idx, rd_last,
    output in_ready, store, w_addr, out_c, bias, value, cout_done,
           pool, load, addr1, addr2, rd_valid
  );

  modport master (
    output in_valid, in_data, pool_done, rd_req, rd_idx, rd_last,
    input  in_ready, store, w_addr, out_c, bias, value, cout_done,
           pool, load, addr1, addr2, rd_valid
  );
endinterface

// File: rtl/layer1_seq.sv
// First-layer sequencer: stores conv results with per-channel bias, waits for
// pooling, then serves pooled-pixel address pairs to the next stage.
module layer1_seq #(
  parameter int unsigned PIXELS = 784,
  parameter int unsigned OC     = 8,
  parameter int unsigned PW     = 14,
  parameter int unsigned PN     = 196
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [2:0]        cfg_ch,
  input  logic signed [7:0] cfg_bias,
  input  logic              start,
  output logic              busy,
  output logic              done,
  layer1_seq_if.slave       bus
);

  localparam int unsigned PIX_W = $clog2(PIXELS);
  localparam int unsigned CH_W  = $clog2(OC);

  typedef enum logic [2:0] {IDLE, STORE, POOL, SERVE, DONE} state_t;

  state_t             state_q, state_d;
  logic [PIX_W-1:0]   pix_q, pix_d;
  logic [CH_W-1:0]    ch_q, ch_d;
  logic signed [7:0]  bias_tab_q [OC];
  logic signed [7:0]  bias_tab_d [OC];
  logic               store_q, store_d;
  logic [9:0]         w_addr_q, w_addr_d;
  logic [3:0]         out_c_q, out_c_d;
  logic signed [7:0]  bias_q, bias_d;
  logic signed [7:0]  value_q, value_d;
  logic               cout_done_q, cout_done_d;
  logic               load_q, load_d;
  logic [9:0]         addr1_q, addr1_d;
  logic [9:0]         addr2_q, addr2_d;
  logic               v1_q, v1_d;
  logic               rd_valid_q, rd_valid_d;
  logic               last1_q, last1_d;
  logic               last2_q, last2_d;

  logic               accept;
  logic [31:0]        idx_w;
  logic [31:0]        nxt_w;

  // Each pooled pixel maps to the top-left of its 2x2 window in the conv plane.
  function automatic logic [9:0] pool_addr(input logic [31:0] idx);
    return 10'((idx / PW) * (4 * PW) + (idx % PW) * 2);
  endfunction

  assign accept = bus.in_valid && (state_q == STORE);
  assign idx_w  = {24'd0, bus.rd_idx};
  assign nxt_w  = (idx_w == PN - 1) ? 32'd0 : idx_w + 32'd1;

  always_comb begin
    state_d     = state_q;
    pix_d       = pix_q;
    ch_d        = ch_q;
    bias_tab_d  = bias_tab_q;
    store_d     = 1'b0;
    w_addr_d    = w_addr_q;
    out_c_d     = out_c_q;
    bias_d      = bias_q;
    value_d     = value_q;
    cout_done_d = 1'b0;
    load_d      = 1'b0;
    addr1_d     = addr1_q;
    addr2_d     = addr2_q;
    v1_d        = 1'b0;
    rd_valid_d  = v1_q;
    last1_d     = 1'b0;
    last2_d     = last1_q;

    case (state_q)
      IDLE: begin
        if (cfg_we) bias_tab_d[cfg_ch] = cfg_bias;
        if (start) begin
          pix_d   = '0;
          ch_d    = '0;
          state_d = STORE;
        end
      end
      STORE: begin
        if (accept) begin
          store_d  = 1'b1;
          w_addr_d = 10'(pix_q);
          out_c_d  = 4'(ch_q);
          value_d  = bus.in_data;
          bias_d   = bias_tab_q[ch_q];
          if (pix_q == PIX_W'(PIXELS - 1)) begin
            pix_d = '0;
            if (ch_q == CH_W'(OC - 1)) begin
              ch_d        = '0;
              cout_done_d = 1'b1;
              state_d     = POOL;
            end else begin
              ch_d = ch_q + CH_W'(1);
            end
          end else begin
            pix_d = pix_q + PIX_W'(1);
          end
        end
      end
      POOL: begin
        if (bus.pool_done) state_d = SERVE;
      end
      SERVE: begin
        if (bus.rd_req) begin
          last1_d = bus.rd_last;
          if (idx_w < PN) begin
            load_d  = 1'b1;
            v1_d    = 1'b1;
            addr1_d = pool_addr(idx_w);
            addr2_d = pool_addr(nxt_w);
          end
        end
        // last2_q coincides with the final rd_valid, so DONE follows it.
        if (last2_q) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pix_q       <= '0;
      ch_q        <= '0;
      bias_tab_q  <= '{default: '0};
      store_q     <= 1'b0;
      w_addr_q    <= '0;
      out_c_q     <= '0;
      bias_q      <= '0;
      value_q     <= '0;
      cout_done_q <= 1'b0;
      load_q      <= 1'b0;
      addr1_q     <= '0;
      addr2_q     <= '0;
      v1_q        <= 1'b0;
      rd_valid_q  <= 1'b0;
      last1_q     <= 1'b0;
      last2_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pix_q       <= pix_d;
      ch_q        <= ch_d;
      bias_tab_q  <= bias_tab_d;
      store_q     <= store_d;
      w_addr_q    <= w_addr_d;
      out_c_q     <= out_c_d;
      bias_q      <= bias_d;
      value_q     <= value_d;
      cout_done_q <= cout_done_d;
      load_q      <= load_d;
      addr1_q     <= addr1_d;
      addr2_q     <= addr2_d;
      v1_q        <= v1_d;
      rd_valid_q  <= rd_valid_d;
      last1_q     <= last1_d;
      last2_q     <= last2_d;
    end
  end

  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign bus.in_ready  = (state_q == STORE);
  assign bus.pool      = (state_q == POOL);
  assign bus.store     = store_q;
  assign bus.w_addr    = w_addr_q;
  assign bus.out_c     = out_c_q;
  assign bus.bias      = bias_q;
  assign bus.value     = value_q;
  assign bus.cout_done = cout_done_q;
  assign bus.load      = load_q;
  assign bus.addr1     = addr1_q;
  assign bus.addr2     = addr2_q;
  assign bus.rd_valid  = rd_valid_q;

endmodule

// File: doc/layer1_seq.md
LAYER1_SEQ -- requirements
Module: layer1_seq

Interface
REQ-001 SHALL have parameters: PIXELS, default 784, conv pixels per channel; OC, default 8, output channels; PW, default 14, pooled row width; PN, default 196, pooled pixels per channel.
REQ-002 SHALL use one clock and an asynchronous, active-low reset: clk in 1, rising-edge clock; rst in 1, asynchronous active-low reset.
REQ-003 SHALL have config ports: cfg_we in 1, bias write strobe; cfg_ch in 3, bias index; cfg_bias in 8 signed, bias value.
REQ-004 SHALL have control ports: start in 1, begin layer; busy out 1, not IDLE; done out 1, one-cycle completion pulse.
REQ-005 SHALL have stream input ports: in_valid in 1; in_ready out 1; in_data in 8 signed, conv result in channel-major, row-major order.
REQ-006 SHALL have memory command ports: store out 1; w_addr out 10; out_c out 4; bias out 8 signed; value out 8 signed; cout_done out 1; pool out 1; pool_done in 1; load out 1; addr1 out 10; addr2 out 10.
REQ-007 SHALL have read-service ports: rd_req in 1; rd_idx in 8, pooled index; rd_last in 1, final request flag; rd_valid out 1, memory data outputs valid.

Function
REQ-008 SHALL implement FSM states IDLE, STORE, POOL, SERVE, DONE.
REQ-009 IDLE: cfg_we=1 SHALL write bias_tab[cfg_ch]<=cfg_bias. cfg_we SHALL be ignored in every other state.
REQ-010 IDLE: start=1 SHALL clear the pixel and channel counters and enter STORE. start SHALL be ignored in every other state.
REQ-011 STORE: in_ready SHALL be 1. On beat in_valid&in_ready, the next cycle SHALL drive store=1, w_addr=pix, out_c=ch, value=in_data, bias=bias_tab[ch], all registered, with 1-cycle latency.
REQ-012 store SHALL be 0 in every cycle that does not follow an accepted beat. w_addr, out_c, bias and value SHALL hold their last values.
REQ-013 Each beat SHALL increment pix. At pix=PIXELS-1, pix SHALL wrap to 0 and ch SHALL increment.
REQ-014 On the beat with ch=OC-1 and pix=PIXELS-1: in_ready SHALL drop the next cycle. cout_done SHALL pulse 1 cycle, concurrent with the final store. The FSM SHALL enter POOL.
REQ-015 POOL: pool SHALL be held 1 until pool_done=1 is sampled. pool SHALL then be 0 from the next cycle, and the FSM SHALL enter SERVE.
REQ-016 A pool_done pulse in any state other than POOL SHALL be ignored.
REQ-017 SERVE: rd_req=1 with rd_idx<PN SHALL register load=1 the next cycle, with addr1 = 56*(rd_idx/PW) + 2*(rd_idx%PW). addr2 SHALL be the same mapping of rd_idx+1.
REQ-018 For addr2, rd_idx=PN-1 SHALL wrap to index 0, giving addr2=0.
REQ-019 rd_valid SHALL pulse 2 cycles after rd_req.
REQ-020 Requests SHALL be pipelined: one per cycle, with no bubbles.
REQ-021 rd_req with rd_idx>=PN SHALL produce no load and no rd_valid.
REQ-022 rd_req&rd_last SHALL enter DONE after that request's rd_valid is issued.
REQ-023 DONE: done SHALL pulse 1 cycle. The FSM SHALL then return to IDLE. bias_tab SHALL be retained.
REQ-024 busy SHALL equal (state != IDLE).
REQ-025 Arithmetic SHALL be unsigned, 10 bits. The maximum addr is 56*13+26=754, so no overflow is possible.

Reset
REQ-026 rst=0 SHALL asynchronously force IDLE and clear pix, ch and the pipeline registers.
REQ-027 rst=0 SHALL force store, pool, load, cout_done, rd_valid, done, in_ready and busy to 0, and w_addr, addr1, addr2, out_c, bias and value to 0.
REQ-028 rst=0 SHALL clear bias_tab to 0.
REQ-029 Reset asserted mid-STORE or mid-POOL SHALL abandon the operation, with no further store, pool or cout_done.
REQ-030 After reset, the block SHALL require a fresh start.

Verification
REQ-031 Config and store: write bias_tab[3]=-5, start, stream 8*784 beats, in_valid stalled every 3rd cycle -> beat 3*784+10 yields store with out_c=3, w_addr=10, bias=-5; exactly 6272 store pulses; one cout_done; in_ready=0 afterwards.
REQ-032 Pool handshake: hold pool_done=0 for 50 cycles -> pool stays 1 for all 50 cycles; pool_done=1 -> pool=0 the next cycle and busy stays 1.
REQ-033 Serve mapping: rd_idx=0, 15, 195 on consecutive cycles -> (addr1,addr2) = (0,2), (58,60), (754,0); load pulses on 3 consecutive cycles; rd_valid 2 cycles after each request.
REQ-034 Out-of-range: rd_idx=200 -> no load and no rd_valid; then rd_idx=5 with rd_last -> addr1=10, rd_valid, done pulse, busy=0.
REQ-035 Reset mid-op: assert rst=0 at beat 1000 of STORE -> all outputs 0 immediately; after release, no store until a new start; bias_tab reads back 0.
REQ-036 Ignored events: start during SERVE and pool_done during STORE -> no state change, verified by an unchanged busy and store count.
